// File: rtl/btb_pkg.sv
// Shared constants for the BTB update controller.
//   BTB_SETS / BTB_WAYS / BTB_TAGW : default geometry (8 sets, 2 ways, tag = PC[31:5])
//   state_t                        : controller FSM encoding
//   SNT/WNT/WT/ST                  : 2-bit branch direction counter values
package btb_pkg;
    localparam int BTB_SETS = 8;
    localparam int BTB_WAYS = 2;
    localparam int BTB_TAGW = 27;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        WRITE  = 2'd2
    } state_t;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/btb_update_ctrl_if.sv
// Bus between the branch-resolution side / BTB array and the update controller.
//   upd_*     : resolved-branch update handshake (valid/ready, pc, taken, target)
//   btb_rd_*  : lookup set index out, combinational array read data back
//   btb_wr_*  : array write port and LRU write
// modport master: update producer + array; modport slave: the controller.
interface btb_update_ctrl_if import btb_pkg::*; #(
    parameter int TAGW = BTB_TAGW
);
    logic            upd_valid;
    logic            upd_ready;
    logic [31:0]     upd_pc;
    logic            upd_taken;
    logic [31:0]     upd_target;

    logic [2:0]      btb_rd_set;
    logic            btb_rd_valid0,  btb_rd_valid1;
    logic [TAGW-1:0] btb_rd_tag0,    btb_rd_tag1;
    logic [31:0]     btb_rd_target0, btb_rd_target1;
    logic [1:0]      btb_rd_state0,  btb_rd_state1;
    logic            btb_rd_lru;

    logic            btb_wr_en;
    logic [2:0]      btb_wr_set;
    logic            btb_wr_way;
    logic            btb_wr_valid;
    logic [TAGW-1:0] btb_wr_tag;
    logic [31:0]     btb_wr_target;
    logic [1:0]      btb_wr_state;
    logic            btb_wr_lru_en;
    logic            btb_wr_lru_val;

    modport master (
        output upd_valid, upd_pc, upd_taken, upd_target,
        output btb_rd_valid0, btb_rd_valid1, btb_rd_tag0, btb_rd_tag1,
        output btb_rd_target0, btb_rd_target1, btb_rd_state0, btb_rd_state1, btb_rd_lru,
        input  upd_ready, btb_rd_set,
        input  btb_wr_en, btb_wr_set, btb_wr_way, btb_wr_valid, btb_wr_tag,
        input  btb_wr_target, btb_wr_state, btb_wr_lru_en, btb_wr_lru_val
    );

    modport slave (
        input  upd_valid, upd_pc, upd_taken, upd_target,
        input  btb_rd_valid0, btb_rd_valid1, btb_rd_tag0, btb_rd_tag1,
        input  btb_rd_target0, btb_rd_target1, btb_rd_state0, btb_rd_state1, btb_rd_lru,
        output upd_ready, btb_rd_set,
        output btb_wr_en, btb_wr_set, btb_wr_way, btb_wr_valid, btb_wr_tag,
        output btb_wr_target, btb_wr_state, btb_wr_lru_en, btb_wr_lru_val
    );
endinterface

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating branch direction counter update.
//   state : current counter value
//   taken : resolved outcome
//   next  : state+1 (capped at ST) if taken, state-1 (floored at SNT) if not
module btb_sat_ctr import btb_pkg::*; (
    input  logic [1:0] state,
    input  logic       taken,
    output logic [1:0] next
);
    always_comb begin
        next = state;
        if (taken) begin
            if (state != ST) next = state + 2'd1;
        end else begin
            if (state != SNT) next = state - 2'd1;
        end
    end
endmodule

// File: rtl/btb_update_ctrl.sv
// BTB update controller: takes one resolved branch at a time, looks up its set,
// and either refreshes the hitting way, allocates a victim (taken miss), or
// drops the update (not-taken miss).
//   clk, rst_n     : clock, async active-low reset
//   flush          : pipeline flush (blocks accept, aborts LOOKUP; WRITE commits)
//   bus (slave)    : update handshake, array read/write port
//   hit_cnt        : saturating count of hit updates
//   alloc_cnt      : saturating count of allocations
//   busy           : an update is in flight
module btb_update_ctrl import btb_pkg::*; #(
    parameter int SETS = BTB_SETS,
    parameter int WAYS = BTB_WAYS,
    parameter int TAGW = BTB_TAGW
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    btb_update_ctrl_if.slave    bus,
    output logic [15:0]         hit_cnt,
    output logic [15:0]         alloc_cnt,
    output logic                busy
);
    localparam int SETW = $clog2(SETS);

    // The array port is fixed at 2 ways x 8 sets with tag = PC[31:5].
    if (WAYS != 2 || SETW != 3 || TAGW != 27) begin : g_bad_geometry
        $error("btb_update_ctrl supports only SETS=8, WAYS=2, TAGW=27");
    end

    state_t st, st_nx;

    logic [31:0]     pc_q;
    logic            taken_q;
    logic [31:0]     target_q;

    logic            wr_way_q;
    logic [1:0]      wr_state_q;
    logic [31:0]     wr_target_q;

    logic [SETW-1:0] set_q;
    logic [TAGW-1:0] tag_q;
    logic            unused_pc_lo;

    assign set_q        = pc_q[2 +: SETW];
    assign tag_q        = pc_q[31:5];
    assign unused_pc_lo = ^pc_q[1:0];

    logic accept;
    assign bus.upd_ready = (st == IDLE) && !flush && rst_n;
    assign accept        = bus.upd_valid && bus.upd_ready;
    assign bus.btb_rd_set = set_q;
    assign busy          = (st != IDLE);

    // Lookup decision, evaluated against the combinational read data.
    logic        hit0, hit1, hit, hit_way, victim, do_wr;
    logic [1:0]  hit_state, sat_nx;
    logic [31:0] hit_target;

    assign hit0       = bus.btb_rd_valid0 && (bus.btb_rd_tag0 == tag_q);
    assign hit1       = bus.btb_rd_valid1 && (bus.btb_rd_tag1 == tag_q);
    assign hit        = hit0 || hit1;
    assign hit_way    = !hit0;   // way 0 wins when both match
    assign hit_state  = hit_way ? bus.btb_rd_state1  : bus.btb_rd_state0;
    assign hit_target = hit_way ? bus.btb_rd_target1 : bus.btb_rd_target0;
    assign victim     = !bus.btb_rd_valid0 ? 1'b0 :
                        !bus.btb_rd_valid1 ? 1'b1 : bus.btb_rd_lru;
    assign do_wr      = hit || taken_q;

    btb_sat_ctr u_sat (
        .state (hit_state),
        .taken (taken_q),
        .next  (sat_nx)
    );

    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    if (accept) st_nx = LOOKUP;
            LOOKUP:  st_nx = (flush || !do_wr) ? IDLE : WRITE;
            WRITE:   st_nx = IDLE;   // flush here is ignored: write commits
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st <= IDLE;
        else        st <= st_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else if (accept) begin
            pc_q     <= bus.upd_pc;
            taken_q  <= bus.upd_taken;
            target_q <= bus.upd_target;
        end
    end

    // Register the decision and bump statistics when LOOKUP commits to WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_way_q    <= 1'b0;
            wr_state_q  <= SNT;
            wr_target_q <= '0;
            hit_cnt     <= '0;
            alloc_cnt   <= '0;
        end else if (st == LOOKUP && !flush && do_wr) begin
            wr_way_q    <= hit ? hit_way : victim;
            wr_state_q  <= hit ? sat_nx  : WT;
            wr_target_q <= (hit && !taken_q) ? hit_target : target_q;
            if (hit) begin
                if (hit_cnt != CNT_MAX) hit_cnt <= hit_cnt + 16'd1;
            end else begin
                if (alloc_cnt != CNT_MAX) alloc_cnt <= alloc_cnt + 16'd1;
            end
        end
    end

    // Write port is live only in WRITE; reset forces st to IDLE, so the
    // strobes drop the moment rst_n falls.
    always_comb begin
        bus.btb_wr_en      = 1'b0;
        bus.btb_wr_set     = '0;
        bus.btb_wr_way     = 1'b0;
        bus.btb_wr_valid   = 1'b0;
        bus.btb_wr_tag     = '0;
        bus.btb_wr_target  = '0;
        bus.btb_wr_state   = '0;
        bus.btb_wr_lru_en  = 1'b0;
        bus.btb_wr_lru_val = 1'b0;
        if (st == WRITE) begin
            bus.btb_wr_en      = 1'b1;
            bus.btb_wr_set     = set_q;
            bus.btb_wr_way     = wr_way_q;
            bus.btb_wr_valid   = 1'b1;
            bus.btb_wr_tag     = tag_q;
            bus.btb_wr_target  = wr_target_q;
            bus.btb_wr_state   = wr_state_q;
            bus.btb_wr_lru_en  = 1'b1;
            bus.btb_wr_lru_val = ~wr_way_q;
        end
    end
endmodule

// File: tb/tb_btb_update_ctrl.sv
module tb_btb_update_ctrl;
    import btb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [15:0] hit_cnt, alloc_cnt;
    logic busy;

    always #5 clk = ~clk;

    btb_update_ctrl_if bus ();

    btb_update_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .hit_cnt   (hit_cnt),
        .alloc_cnt (alloc_cnt),
        .busy      (busy)
    );

    // Behavioural BTB array contents (the environment the controller reads).
    logic        m_v   [8][2];
    logic [26:0] m_tag [8][2];
    logic [31:0] m_tgt [8][2];
    logic [1:0]  m_st  [8][2];
    logic        m_lru [8];

    always_comb begin
        bus.btb_rd_valid0  = m_v  [bus.btb_rd_set][0];
        bus.btb_rd_valid1  = m_v  [bus.btb_rd_set][1];
        bus.btb_rd_tag0    = m_tag[bus.btb_rd_set][0];
        bus.btb_rd_tag1    = m_tag[bus.btb_rd_set][1];
        bus.btb_rd_target0 = m_tgt[bus.btb_rd_set][0];
        bus.btb_rd_target1 = m_tgt[bus.btb_rd_set][1];
        bus.btb_rd_state0  = m_st [bus.btb_rd_set][0];
        bus.btb_rd_state1  = m_st [bus.btb_rd_set][1];
        bus.btb_rd_lru     = m_lru[bus.btb_rd_set];
    end

    int total = 0;
    int bad   = 0;
    int exp_hit = 0;
    int exp_alloc = 0;

    // Last observed write, for the directed constant checks.
    logic [2:0]  o_set;
    logic        o_way, o_lru;
    logic [26:0] o_tag;
    logic [31:0] o_tgt;
    logic [1:0]  o_st;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 normal, 1 flush in LOOKUP, 2 reset during WRITE, 3 flush during WRITE
    task automatic run_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input int mode);
        int s, w, nst;
        logic [26:0] tg;
        logic h0, h1, ew;
        logic [31:0] etgt;

        // Reference decision from the array contents before the update.
        s  = int'(pc[4:2]);
        tg = pc[31:5];
        h0 = m_v[s][0] && m_tag[s][0] == tg;
        h1 = m_v[s][1] && m_tag[s][1] == tg;
        ew = 1'b0; w = 0; nst = 0; etgt = tgt;
        if (h0 || h1) begin
            ew = 1'b1;
            w = h0 ? 0 : 1;
            nst = int'(m_st[s][w]);
            nst = tk ? ((nst == 3) ? 3 : nst + 1) : ((nst == 0) ? 0 : nst - 1);
            if (!tk) etgt = m_tgt[s][w];
        end else if (tk) begin
            ew = 1'b1;
            if (!m_v[s][0]) w = 0;
            else if (!m_v[s][1]) w = 1;
            else w = int'(m_lru[s]);
            nst = 2;
        end

        @(negedge clk);
        chk("idle_ready", bus.upd_ready, 1);
        bus.upd_valid = 1'b1; bus.upd_pc = pc; bus.upd_taken = tk; bus.upd_target = tgt;
        @(posedge clk); #1;
        bus.upd_valid = 1'b0;

        @(negedge clk);   // cycle N+1: LOOKUP
        chk("lookup_busy", busy, 1);
        chk("lookup_ready", bus.upd_ready, 0);
        chk("lookup_wr_en", bus.btb_wr_en, 0);
        chk("lookup_rd_set", bus.btb_rd_set, 64'(s));

        if (mode == 1) begin
            flush = 1'b1;
            @(negedge clk);
            chk("flush_lk_busy", busy, 0);
            chk("flush_lk_wr_en", bus.btb_wr_en, 0);
            chk("flush_lk_hit", hit_cnt, 64'(exp_hit));
            chk("flush_lk_alloc", alloc_cnt, 64'(exp_alloc));
            flush = 1'b0;
            return;
        end

        @(negedge clk);   // cycle N+2
        if (!ew) begin
            chk("nowr_wr_en", bus.btb_wr_en, 0);
            chk("nowr_lru_en", bus.btb_wr_lru_en, 0);
            chk("nowr_ready", bus.upd_ready, 1);
            chk("nowr_hit", hit_cnt, 64'(exp_hit));
            chk("nowr_alloc", alloc_cnt, 64'(exp_alloc));
            return;
        end

        if (h0 || h1) exp_hit++; else exp_alloc++;
        chk("wr_en", bus.btb_wr_en, 1);
        chk("wr_lru_en", bus.btb_wr_lru_en, 1);
        chk("wr_set", bus.btb_wr_set, 64'(s));
        chk("wr_way", bus.btb_wr_way, 64'(w));
        chk("wr_valid", bus.btb_wr_valid, 1);
        chk("wr_tag", bus.btb_wr_tag, tg);
        chk("wr_target", bus.btb_wr_target, etgt);
        chk("wr_state", bus.btb_wr_state, 64'(nst));
        chk("wr_lru_val", bus.btb_wr_lru_val, 64'(1 - w));
        chk("wr_ready", bus.upd_ready, 0);
        chk("wr_hit_cnt", hit_cnt, 64'(exp_hit));
        chk("wr_alloc_cnt", alloc_cnt, 64'(exp_alloc));
        o_set = bus.btb_wr_set; o_way = bus.btb_wr_way; o_tag = bus.btb_wr_tag;
        o_tgt = bus.btb_wr_target; o_st = bus.btb_wr_state; o_lru = bus.btb_wr_lru_val;

        if (mode == 2) begin
            rst_n = 1'b0;
            #1;
            chk("rst_wr_en", bus.btb_wr_en, 0);
            chk("rst_lru_en", bus.btb_wr_lru_en, 0);
            chk("rst_hit", hit_cnt, 0);
            chk("rst_alloc", alloc_cnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_ready", bus.upd_ready, 0);
            exp_hit = 0; exp_alloc = 0;
            #1 rst_n = 1'b1;
            return;
        end

        if (mode == 3) flush = 1'b1;
        m_v[s][w] = 1'b1; m_tag[s][w] = tg; m_tgt[s][w] = etgt;
        m_st[s][w] = 2'(nst); m_lru[s] = (w == 0);

        @(negedge clk);   // cycle N+3
        chk("post_wr_en", bus.btb_wr_en, 0);
        chk("post_busy", busy, 0);
        flush = 1'b0;
        #1 chk("post_ready", bus.upd_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            m_lru[i] = 1'b0;
            for (int j = 0; j < 2; j++) begin
                m_v[i][j] = 1'b0; m_tag[i][j] = '0; m_tgt[i][j] = '0; m_st[i][j] = '0;
            end
        end
        bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0; bus.upd_target = '0;

        #1;
        chk("inrst_ready", bus.upd_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_hit", hit_cnt, 0);
        chk("reset_alloc", alloc_cnt, 0);
        chk("reset_wr_en", bus.btb_wr_en, 0);
        chk("reset_rd_set", bus.btb_rd_set, 0);
        chk("reset_ready", bus.upd_ready, 1);

        // Taken update into empty set 1 allocates way 0.
        run_upd(32'h0000_1004, 1'b1, 32'h0000_2000, 0);
        chk("a_set", o_set, 1); chk("a_way", o_way, 0); chk("a_tag", o_tag, 27'h80);
        chk("a_state", o_st, 2'b10); chk("a_lru", o_lru, 1); chk("a_alloc", alloc_cnt, 1);

        // Hit on way 1 at strongly-taken, taken again: stays 11.
        m_v[3][1] = 1'b1; m_tag[3][1] = 27'h102; m_st[3][1] = 2'b11; m_tgt[3][1] = 32'h100;
        run_upd(32'h0000_204C, 1'b1, 32'h0000_5000, 0);
        chk("h_way", o_way, 1); chk("h_state", o_st, 2'b11); chk("h_lru", o_lru, 0);
        chk("h_hit", hit_cnt, 1);

        // Hit at strongly-not-taken, not taken: floors at 00, keeps stored target.
        m_v[5][0] = 1'b1; m_tag[5][0] = 27'h200; m_st[5][0] = 2'b00; m_tgt[5][0] = 32'h3000;
        run_upd(32'h0000_4014, 1'b0, 32'h0000_7777, 0);
        chk("n_state", o_st, 2'b00); chk("n_target", o_tgt, 32'h3000);

        // Both ways valid, miss, LRU points at way 1.
        m_v[6][0] = 1'b1; m_tag[6][0] = 27'h1; m_v[6][1] = 1'b1; m_tag[6][1] = 27'h2;
        m_lru[6] = 1'b1;
        run_upd(32'h0000_8018, 1'b1, 32'h0000_9000, 0);
        chk("v_way", o_way, 1); chk("v_lru", o_lru, 0);

        // Not-taken miss: no write.
        run_upd(32'h0000_9008, 1'b0, 32'h0000_1234, 0);

        // Flush during LOOKUP aborts; flush in IDLE blocks accept.
        run_upd(32'h0000_1004, 1'b1, 32'h0000_2222, 1);
        @(negedge clk);
        flush = 1'b1; bus.upd_valid = 1'b1; bus.upd_pc = 32'h0000_1004; bus.upd_taken = 1'b1;
        #1 chk("flush_idle_ready", bus.upd_ready, 0);
        @(posedge clk); #1;
        chk("flush_idle_busy", busy, 0);
        bus.upd_valid = 1'b0; flush = 1'b0;

        // Flush during WRITE still commits; reset during WRITE discards.
        run_upd(32'h0000_1004, 1'b0, 32'h0000_0000, 3);
        run_upd(32'h0000_1004, 1'b1, 32'h0000_2000, 2);

        // Randomized traffic over a small tag pool to mix hits, misses, evictions.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] rpc;
            int r;
            rpc = (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2);
            r = int'($urandom_range(0, 9));
            run_upd(rpc, 1'($urandom_range(0, 1)), $urandom,
                    (r == 0) ? 1 : (r == 1) ? 3 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL take parameters SETS (default 8, number of sets), WAYS (default 2, number of ways), and TAGW (default 27, tag width, PC[31:5]).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updated on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port upd_valid, input, 1 bit, and port upd_ready, output, 1 bit: resolved-branch update handshake.
REQ-005 SHALL have ports upd_pc (input, 32 bits), upd_taken (input, 1 bit), and upd_target (input, 32 bits): resolved branch PC, outcome and target.
REQ-006 SHALL have port flush, input, 1 bit: pipeline flush.
REQ-007 SHALL have port btb_rd_set, output, 3 bits: lookup set index.
REQ-008 SHALL have input ports btb_rd_valid0/1 (1 bit each), btb_rd_tag0/1 (TAGW bits each), btb_rd_target0/1 (32 bits each), btb_rd_state0/1 (2 bits each), and btb_rd_lru (1 bit): combinational array read data for btb_rd_set.
REQ-009 SHALL have output ports btb_wr_en (1 bit), btb_wr_set (3 bits), btb_wr_way (1 bit), btb_wr_valid (1 bit), btb_wr_tag (TAGW bits), btb_wr_target (32 bits), btb_wr_state (2 bits): array write port.
REQ-010 SHALL have output ports btb_wr_lru_en (1 bit) and btb_wr_lru_val (1 bit): LRU write.
REQ-011 SHALL have output ports hit_cnt (16 bits), alloc_cnt (16 bits), and busy (1 bit): statistics and activity flag.

Function
REQ-012 SHALL implement FSM IDLE -> LOOKUP -> WRITE -> IDLE, with LOOKUP -> IDLE used for the no-write and flush cases.
REQ-013 SHALL drive upd_ready = (state==IDLE) && !flush; a transfer occurs on upd_valid && upd_ready and latches pc, taken and target.
REQ-014 SHALL derive set = pc[4:2] and tag = pc[31:5]; btb_rd_set is driven from the latched set in every state.
REQ-015 SHALL, in LOOKUP, compute hitN = btb_rd_validN && (btb_rd_tagN == tag), give way 0 priority when both hit, and register the decision.
REQ-016 SHALL, on a hit to way w: write way w with valid=1; state saturating +1 if taken (max 3), -1 if not taken (min 0); target = upd_target if taken, else the stored target; lru_val = ~w; hit_cnt +1.
REQ-017 SHALL, on a miss with taken: select the victim as the first invalid way (way 0 first), else btb_rd_lru; write valid=1, tag, target=upd_target, state=2'b10; lru_val = ~victim; alloc_cnt +1.
REQ-018 SHALL, on a miss with not-taken: perform no write and go LOOKUP -> IDLE.
REQ-019 SHALL assert btb_wr_en and btb_wr_lru_en for exactly the one WRITE cycle; outside WRITE, all btb_wr_* outputs SHALL be 0.
REQ-020 SHALL meet latency: accept at edge N; LOOKUP during cycle N+1; write strobes during cycle N+2; upd_ready high again in cycle N+3 (N+2 for no-write); at most one update in flight.
REQ-021 SHALL, on flush during LOOKUP, abort to IDLE with no write and no counter change.
REQ-022 SHALL, on flush during WRITE, complete the write (commit point).
REQ-023 SHALL, on flush in IDLE, accept no update.
REQ-024 SHALL saturate hit_cnt and alloc_cnt at 16'hFFFF with no wrap.
REQ-025 SHALL drive busy = (state != IDLE).

Reset
REQ-026 SHALL, on rst_n low, immediately set state=IDLE, latched pc/target/taken=0, hit_cnt=alloc_cnt=0, and all btb_wr_* outputs=0, regardless of the current state.
REQ-027 SHALL, on rst_n asserted mid-WRITE, drop btb_wr_en combinationally with the reset; the partial update is discarded.
REQ-028 SHALL accept no update while rst_n is low.

Structure
REQ-029 SHALL place SETS, WAYS, TAGW, the FSM state encoding, and counter constants (SNT=00, WNT=01, WT=10, ST=11) in shared package btb_pkg.
REQ-030 SHALL implement the 2-bit saturating update as sub-module btb_sat_ctr (in: state, taken; out: next state).

Verification
REQ-031 SHALL cover: after reset, taken update pc=0x0000_1004, target=0x0000_2000, set 1 empty -> at N+2 wr_set=1, wr_way=0, wr_tag=0x80, wr_state=10, wr_lru_val=1, alloc_cnt=1.
REQ-032 SHALL cover: hit on way 1 with state=11, taken -> wr_way=1, wr_state=11, wr_lru_val=0, hit_cnt=1.
REQ-033 SHALL cover: hit with state=00, not-taken, target 0x3000 stored -> wr_state=00, wr_target=0x3000.
REQ-034 SHALL cover: both ways valid, miss, btb_rd_lru=1, taken -> wr_way=1, wr_lru_val=0.
REQ-035 SHALL cover: miss with not-taken -> no wr_en; upd_ready high at N+2; counters unchanged.
REQ-036 SHALL cover: flush in LOOKUP -> no write, IDLE next cycle; rst_n low during WRITE -> wr_en=0 immediately, counters=0.
